// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage of the multi-cycle MIPS-subset core. It owns the
// program counter and fetches one word per instruction over a request/valid
// handshake. It holds the word stable while the instruction executes, then
// selects the next PC from the jr/J/branch controls.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   imem_req, imem_addr      one-cycle fetch request and its byte address (= pc)
//   imem_rvalid, imem_rdata  returned instruction word
//   inst, opcode             registered instruction and its opcode field
//   inst_valid               high while inst is executing
//   pc, pc_plus4             current instruction address and its successor
//   exec_done                datapath finished the current instruction
//   J, beq, bne, jr, zero    next-PC controls for the current instruction
//   jr_target                rs value used by jr
//   retired                  completed-instruction counter
//   fault                    sticky misaligned-target flag
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [5:0]  opcode,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        exec_done,
    input  logic        J,
    input  logic        beq,
    input  logic        bne,
    input  logic        jr,
    input  logic        zero,
    input  logic [31:0] jr_target,
    output logic [31:0] retired,
    output logic        fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] retired_reg, retired_next;
    logic        fault_reg, fault_next;

    logic [31:0] branch_offset;
    logic        branch_taken;
    logic [31:0] target;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            pc_reg      <= RESET_PC;
            inst_reg    <= 32'h0;
            retired_reg <= 32'h0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            inst_reg    <= inst_next;
            retired_reg <= retired_next;
            fault_reg   <= fault_next;
        end
    end

    assign pc_plus4 = pc_reg + 32'd4;

    // Sign-extended word offset; the add wraps naturally at 32 bits.
    assign branch_offset = {{14{inst_reg[15]}}, inst_reg[15:0], 2'b00};
    // With beq and bne both set, either condition takes the branch.
    assign branch_taken  = (beq & zero) | (bne & ~zero);

    // Next-PC selection, jr has the highest priority.
    always_comb begin
        target = pc_plus4;
        if (jr) begin
            target = jr_target;
        end else if (J) begin
            target = {pc_plus4[31:28], inst_reg[25:0], 2'b00};
        end else if (branch_taken) begin
            target = pc_plus4 + branch_offset;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        inst_next    = inst_reg;
        retired_next = retired_reg;
        fault_next   = fault_reg;
        case (state_reg)
            IDLE:  state_next = FETCH;
            // A response in the request cycle itself is not accepted.
            FETCH: state_next = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    inst_next  = imem_rdata;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    if (target[1:0] != 2'b00) begin
                        // Keep pc on the faulting instruction for diagnosis.
                        fault_next = 1'b1;
                        state_next = HALT;
                    end else begin
                        pc_next      = target;
                        retired_next = retired_reg + 32'd1;
                        state_next   = FETCH;
                    end
                end
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    assign imem_req   = (state_reg == FETCH);
    assign inst_valid = (state_reg == EXEC);
    assign imem_addr  = pc_reg;
    assign pc         = pc_reg;
    assign inst       = inst_reg;
    assign opcode     = inst_reg[31:26];
    assign retired    = retired_reg;
    assign fault      = fault_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exec_done;
    logic        j_in;
    logic        beq;
    logic        bne;
    logic        jr;
    logic        zero;
    logic [31:0] jr_target;
    logic [31:0] retired;
    logic        fault;

    int compared;
    int mismatched;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .opcode     (opcode),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .exec_done  (exec_done),
        .J          (j_in),
        .beq        (beq),
        .bne        (bne),
        .jr         (jr),
        .zero       (zero),
        .jr_target  (jr_target),
        .retired    (retired),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        exec_done = 1'b0;
        j_in      = 1'b0;
        beq       = 1'b0;
        bne       = 1'b0;
        jr        = 1'b0;
        zero      = 1'b0;
        jr_target = 32'h0;
    endtask

    // Runs one instruction starting with the DUT in FETCH. lat = number of
    // WAIT cycles (rvalid on the last), hold = EXEC cycles with exec_done low.
    task automatic run_instr(input logic [31:0] exp_pc, input logic [31:0] word,
                             input int lat, input int hold,
                             input logic jr_i, input logic j_i, input logic beq_i,
                             input logic bne_i, input logic zero_i,
                             input logic [31:0] jrt);
        logic [31:0] exp_p4;
        logic [5:0]  exp_op;
        exp_p4 = exp_pc + 32'd4;
        exp_op = word[31:26];
        chk("fetch_req", {31'h0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        chk("fetch_ivalid", {31'h0, inst_valid}, 32'd0);
        imem_rvalid = 1'b1;           // ignored during FETCH
        imem_rdata  = 32'hBAD0_BAD0;
        step();
        imem_rvalid = 1'b0;
        for (int k = 1; k < lat; k++) begin
            chk("wait_req", {31'h0, imem_req}, 32'd0);
            chk("wait_ivalid", {31'h0, inst_valid}, 32'd0);
            step();
        end
        chk("wait_req", {31'h0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        for (int k = 0; k < hold; k++) begin
            chk("hold_ivalid", {31'h0, inst_valid}, 32'd1);
            step();
        end
        chk("exec_ivalid", {31'h0, inst_valid}, 32'd1);
        chk("exec_inst", inst, word);
        chk("exec_opcode", {26'h0, opcode}, {26'h0, exp_op});
        chk("exec_pc", pc, exp_pc);
        chk("exec_pc4", pc_plus4, exp_p4);
        exec_done = 1'b1;
        jr        = jr_i;
        j_in      = j_i;
        beq       = beq_i;
        bne       = bne_i;
        zero      = zero_i;
        jr_target = jrt;
        step();
        clear_ctrl();
        $display("instr pc=%h inst=%h retired=%0d fault=%0d", exp_pc, word, retired, fault);
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst         = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        clear_ctrl();

        // Reset state
        step();
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h4);
        chk("rst_inst", inst, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'd0);
        chk("rst_ivalid", {31'h0, inst_valid}, 32'd0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'd0);
        rst = 1'b1;
        chk("idle_req", {31'h0, imem_req}, 32'd0);
        step();
        $display("reset released, first request addr=%h", imem_addr);

        // Sequential fetch; third instruction is a taken beq back to 4
        run_instr(32'h0, 32'h2000_0001, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        run_instr(32'h4, 32'h2000_0002, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        run_instr(32'h8, 32'h1000_FFFE, 1, 0, 0, 0, 1, 0, 1, 32'h0);
        chk("retired_after_3", retired, 32'd3);
        // Held-off exec_done, then not-taken beq falls through to 12
        run_instr(32'h4, 32'h2000_0003, 1, 2, 0, 0, 0, 0, 0, 32'h0);
        run_instr(32'h8, 32'h1000_FFFE, 1, 0, 0, 0, 1, 0, 0, 32'h0);
        // jr beats J
        run_instr(32'hC, 32'h0800_0040, 1, 0, 1, 1, 0, 0, 0, 32'h200);
        run_instr(32'h200, 32'h0000_0008, 1, 0, 1, 0, 0, 0, 0, 32'h1000_0000);
        // J keeps pc_plus4[31:28]
        run_instr(32'h1000_0000, 32'h0800_0040, 1, 0, 0, 1, 0, 0, 0, 32'h0);
        // Memory latency of 4 cycles
        run_instr(32'h1000_0100, 32'h0000_0008, 4, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC);
        // pc_plus4 wraps to 0
        run_instr(32'hFFFF_FFFC, 32'h2000_0004, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        // beq and bne together with zero=0: taken, 4 + 16
        run_instr(32'h0, 32'h1000_0004, 1, 0, 0, 0, 1, 1, 0, 32'h0);
        chk("retired_before_fault", retired, 32'd11);
        // Misaligned jr target
        run_instr(32'h14, 32'h0000_0008, 2, 0, 1, 0, 0, 0, 0, 32'h202);
        for (int k = 0; k < 3; k++) begin
            chk("halt_fault", {31'h0, fault}, 32'd1);
            chk("halt_pc", pc, 32'h14);
            chk("halt_retired", retired, 32'd11);
            chk("halt_req", {31'h0, imem_req}, 32'd0);
            chk("halt_ivalid", {31'h0, inst_valid}, 32'd0);
            step();
        end

        // Asynchronous reset clears the fault
        rst = 1'b0;
        #1;
        chk("rst2_fault", {31'h0, fault}, 32'd0);
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_retired", retired, 32'h0);
        chk("rst2_inst", inst, 32'h0);
        step();
        rst = 1'b1;
        step();
        $display("second reset released, req=%0d", imem_req);

        // Reset during EXEC, then a stale response
        chk("r3_req", {31'h0, imem_req}, 32'd1);
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2000_0005;
        step();
        imem_rvalid = 1'b0;
        chk("r3_exec", {31'h0, inst_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("r3_ivalid_clr", {31'h0, inst_valid}, 32'd0);
        chk("r3_inst_clr", inst, 32'h0);
        step();
        rst         = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEC;
        step();
        chk("stale_req", {31'h0, imem_req}, 32'd1);
        chk("stale_inst_idle", inst, 32'h0);
        step();
        imem_rvalid = 1'b0;
        chk("stale_inst_fetch", inst, 32'h0);
        chk("stale_ivalid", {31'h0, inst_valid}, 32'd0);
        step();
        chk("stale_still_wait", {31'h0, inst_valid}, 32'd0);
        chk("stale_pc", pc, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2000_0006;
        step();
        imem_rvalid = 1'b0;
        chk("recover_inst", inst, 32'h2000_0006);
        chk("recover_ivalid", {31'h0, inst_valid}, 32'd1);
        $display("recovery capture inst=%h", inst);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
